matmul_sequencer: RTL

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/matmul_sequencer.sv
// Address/control sequencer for C = A x B on N x N matrices held in row-major memories.
// Per output element it issues N operand reads, drains the accumulator for one cycle, then writes C.
module matmul_sequencer #(
  parameter int N = 4,
  localparam int IW = $clog2(N),
  localparam int AW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic          rd_en,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic [AW-1:0] c_addr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          c_we,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

  localparam logic [IW-1:0] LAST = IW'(N-1);
  localparam logic [AW-1:0] NA   = AW'(N);

  state_t        state, state_n;
  logic [IW-1:0] i, j, k;
  logic [IW-1:0] i_n, j_n, k_n;

  // acc_en/acc_clr trail the read strobe by the one-cycle memory latency
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      acc_en  <= 1'b0;
      acc_clr <= 1'b0;
    end else begin
      state   <= state_n;
      i       <= i_n;
      j       <= j_n;
      k       <= k_n;
      acc_en  <= rd_en;
      acc_clr <= rd_en & (k == '0);
    end
  end

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    rd_en   = 1'b0;
    c_we    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          i_n     = '0;
          j_n     = '0;
          k_n     = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        rd_en = ~hold;
        if (!hold) begin
          if (k == LAST) begin
            k_n     = '0;
            state_n = DRAIN;
          end else begin
            k_n = k + 1'b1;
          end
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        c_we = 1'b1;
        if (j != LAST) begin
          j_n     = j + 1'b1;
          state_n = RUN;
        end else begin
          j_n = '0;
          if (i != LAST) begin
            i_n     = i + 1'b1;
            state_n = RUN;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Addresses are only meaningful while a pass is in flight; park them at 0 otherwise
  always_comb begin
    a_addr = '0;
    b_addr = '0;
    c_addr = '0;
    if (busy) begin
      a_addr = AW'(i) * NA + AW'(k);
      b_addr = AW'(k) * NA + AW'(j);
      c_addr = AW'(i) * NA + AW'(j);
    end
  end

endmodule
